// File: rtl/captura_vga_pkg.sv
// captura_vga_pkg: capture FSM states, default frame geometry and pixel packing.
// Define CAPTURA_GRIS_EN for 8-bit grayscale pixels; otherwise RGB332.
package captura_vga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ESPERA_VSYNC,
    CAPTURA,
    FIN
  } estado_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  function automatic logic [7:0] pixel_conv(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
`ifdef CAPTURA_GRIS_EN
    logic [9:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[9:2];
`else
    logic unused_bits;
    unused_bits = ^{r[4:0], g[4:0], b[5:0]};
    return {r[7:5], g[7:5], b[7:6]};
`endif
  endfunction

endpackage

// File: rtl/detector_flancos.sv
// detector_flancos: input register plus registered rise/fall pulses,
// each pulse aligned with the first cycle of the new registered level.
module detector_flancos #(
  parameter int          W    = 3,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clock_25,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      q    <= INIT;
      rise <= '0;
      fall <= '0;
    end else begin
      q    <= din;
      rise <= din & ~q;
      fall <= ~din & q;
    end
  end

endmodule

// File: rtl/captura_vga.sv
// captura_vga: captures one armed VGA frame, packing 4 pixels per 32-bit write.
// Pixel format chosen by CAPTURA_GRIS_EN (gray) or its absence (RGB332).
module captura_vga
  import captura_vga_pkg::*;
#(
  parameter int          H_ACTIVE  = H_ACTIVE_DEF,
  parameter int          V_ACTIVE  = V_ACTIVE_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        n_blank,
  output logic [31:0] address,
  output logic [31:0] data_out,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] H_LIM = 16'(H_ACTIVE);
  localparam logic [15:0] V_LIM = 16'(V_ACTIVE);

  estado_t     estado;
  logic [7:0]  r_q;
  logic [7:0]  g_q;
  logic [7:0]  b_q;
  logic [2:0]  sync_q;
  logic [2:0]  sync_rise;
  logic [2:0]  sync_fall;
  logic        nb_q;
  logic        nb_rise;
  logic        nb_fall;
  logic        vs_fall;
  logic [15:0] pix_cnt;
  logic [15:0] line_cnt;
  logic [1:0]  fill;
  logic [23:0] acc;
  logic [29:0] idx;
  logic [7:0]  pix;
  logic [15:0] col;
  logic [15:0] line_nx;
  logic        pix_ok;
  logic        unused;

  detector_flancos #(
    .W    (3),
    .INIT (3'b011)
  ) u_flancos (
    .clock_25 (clock_25),
    .reset    (reset),
    .din      ({n_blank, vsync, hsync}),
    .q        (sync_q),
    .rise     (sync_rise),
    .fall     (sync_fall)
  );

  assign nb_q    = sync_q[2];
  assign nb_rise = sync_rise[2];
  assign nb_fall = sync_fall[2];
  assign vs_fall = sync_fall[1];
  assign unused  = ^{sync_q[1:0], sync_rise[1:0], sync_fall[0]};

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= red;
      g_q <= green;
      b_q <= blue;
    end
  end

  // First pixel of a line restarts the column and opens the next line.
  always_comb begin
    pix     = pixel_conv(r_q, g_q, b_q);
    col     = nb_rise ? 16'd0 : pix_cnt;
    line_nx = nb_rise ? line_cnt + 16'd1 : line_cnt;
    pix_ok  = (col < H_LIM) && (line_nx <= V_LIM) && (line_nx != 16'd0);
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      estado   <= IDLE;
      address  <= BASE_ADDR;
      data_out <= '0;
      we       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      fill     <= '0;
      acc      <= '0;
      idx      <= '0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      unique case (estado)
        IDLE: begin
          if (start) begin
            estado <= ESPERA_VSYNC;
            busy   <= 1'b1;
            error  <= 1'b0;
            idx    <= '0;
          end
        end
        ESPERA_VSYNC: begin
          if (vs_fall) begin
            estado   <= CAPTURA;
            pix_cnt  <= '0;
            line_cnt <= '0;
            fill     <= '0;
            acc      <= '0;
          end
        end
        CAPTURA: begin
          if (vs_fall || nb_fall) begin
            // Partial word goes out zero-padded before leaving the line.
            if (fill != 2'd0) begin
              we       <= 1'b1;
              address  <= BASE_ADDR + {idx, 2'b00};
              data_out <= {8'h00, acc};
              idx      <= idx + 30'd1;
            end
            fill <= '0;
            acc  <= '0;
            if (vs_fall) begin
              error  <= 1'b1;
              estado <= FIN;
            end else begin
              if (pix_cnt != H_LIM) error <= 1'b1;
              if (line_cnt == V_LIM) estado <= FIN;
            end
          end else if (nb_q) begin
            pix_cnt  <= (col == 16'hFFFF) ? col : col + 16'd1;
            line_cnt <= line_nx;
            if (!pix_ok) begin
              error <= 1'b1;
            end else if (fill == 2'd3) begin
              we       <= 1'b1;
              address  <= BASE_ADDR + {idx, 2'b00};
              data_out <= {pix, acc};
              idx      <= idx + 30'd1;
              fill     <= '0;
              acc      <= '0;
            end else begin
              acc[{fill, 3'b000} +: 8] <= pix;
              fill <= fill + 2'd1;
            end
          end
        end
        FIN: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          estado <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_captura_vga.sv
// tb_captura_vga: directed frames with a write/done scoreboard on a small
// frame geometry; expected pixel bytes follow CAPTURA_GRIS_EN.
module tb_captura_vga;

  localparam int          H    = 16;
  localparam int          V    = 6;
  localparam logic [31:0] BASE = 32'h1000_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        n_blank;
  logic [31:0] address;
  logic [31:0] data_out;
  logic        we;
  logic        busy;
  logic        done;
  logic        error;

  captura_vga #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .BASE_ADDR (BASE)
  ) dut (
    .clock_25 (clk),
    .reset    (reset),
    .start    (start),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .hsync    (hsync),
    .vsync    (vsync),
    .n_blank  (n_blank),
    .address  (address),
    .data_out (data_out),
    .we       (we),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t  wr_q[$];
  bit   done_q[$];
  wr_t  e;
  bit   de;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   lens[6];
  int   m_idx;
  int   m_fill;
  logic [31:0] m_buf;
  bit   m_err;

  logic [23:0] tbl_rgb[8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h808080,
                              24'hFFFFFF, 24'h102030, 24'hC86432, 24'h000000};
`ifdef CAPTURA_GRIS_EN
  logic [7:0] tbl_px[8] = '{8'h3F, 8'h7F, 8'h3F, 8'h80,
                            8'hFF, 8'h20, 8'h70, 8'h00};
`else
  logic [7:0] tbl_px[8] = '{8'hE0, 8'h1C, 8'h03, 8'h92,
                            8'hFF, 8'h04, 8'hCC, 8'h00};
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (we) begin
        total++;
        if (wr_q.size() == 0) begin
          bad++;
          $display("FAIL wr_extra addr=%h data=%h cyc=%0d exp=none",
                   address, data_out, cyc);
        end else begin
          e = wr_q.pop_front();
          if (address !== e.a || data_out !== e.d || cyc != e.c) begin
            bad++;
            $display("FAIL wr addr=%h data=%h cyc=%0d exp addr=%h data=%h cyc=%0d",
                     address, data_out, cyc, e.a, e.d, e.c);
          end
        end
      end
      if (done) begin
        total++;
        if (done_q.size() == 0) begin
          bad++;
          $display("FAIL done_extra error=%b exp=none", error);
        end else begin
          de = done_q.pop_front();
          if (error !== de || we !== 1'b0) begin
            bad++;
            $display("FAIL done error=%b we=%b exp error=%b we=0", error, we, de);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [31:0] d, input int c);
    wr_t w;
    w.a = BASE + 32'(m_idx * 4);
    w.d = d;
    w.c = c;
    wr_q.push_back(w);
    m_idx++;
  endtask

  task automatic do_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_idx = 0;
    m_err = 1'b0;
    @(negedge clk);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("error_after_start", {31'd0, error}, 32'd0);
  endtask

  task automatic frame(input int nl, input int st_line, input int rst_line, input bit armed);
    int k;
    tick();
    n_blank = 1'b1;
    {red, green, blue} = 24'h555555;
    repeat (5) tick();
    n_blank = 1'b0;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
    vsync = 1'b1;
    repeat (3) tick();
    m_fill = 0;
    m_buf  = '0;
    for (int l = 0; l < nl; l++) begin
      if (l == rst_line) begin
        tick();
        reset = 1'b0;
        #1;
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_address", address, BASE);
        chk("rst_data", data_out, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        wr_q.delete();
        done_q.delete();
        return;
      end
      tick();
      hsync = 1'b0;
      tick();
      hsync = 1'b1;
      repeat (2) tick();
      for (int c = 0; c < lens[l]; c++) begin
        tick();
        k = (l + c) % 8;
        n_blank = 1'b1;
        {red, green, blue} = tbl_rgb[k];
        start = (l == st_line && c == 3);
        if (armed && c < H) begin
          m_buf[8*m_fill +: 8] = tbl_px[k];
          m_fill++;
          if (m_fill == 4) begin
            push_wr(m_buf, cyc + 2);
            m_buf  = '0;
            m_fill = 0;
          end
        end
      end
      tick();
      n_blank = 1'b0;
      start = 1'b0;
      {red, green, blue} = 24'h0;
      if (armed) begin
        if (lens[l] != H) m_err = 1'b1;
        if (m_fill != 0) begin
          push_wr(m_buf, cyc + 2);
          m_buf  = '0;
          m_fill = 0;
        end
        if (l == V - 1) done_q.push_back(m_err);
      end
      repeat (4) tick();
    end
    if (nl < V) begin
      tick();
      vsync = 1'b0;
      if (armed) begin
        m_err = 1'b1;
        done_q.push_back(m_err);
      end
      repeat (2) tick();
      vsync = 1'b1;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk("done_pending", done_q.size(), 32'd0);
    chk("writes_pending", wr_q.size(), 32'd0);
    repeat (2) tick();
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    hsync   = 1'b1;
    vsync   = 1'b1;
    n_blank = 1'b0;
    {red, green, blue} = 24'h0;
    m_idx = 0;
    m_err = 1'b0;
    #2 reset = 1'b0;
    #3;
    chk("init_address", address, BASE);
    chk("init_data", data_out, 32'd0);
    chk("init_we_busy_done_err", {28'd0, we, busy, done, error}, 32'd0);
    tick();
    reset = 1'b1;
    repeat (3) tick();

    // Full frame, extra start pulse on line 2.
    do_start();
    lens = '{16, 16, 16, 16, 16, 16};
    frame(6, 2, -1, 1'b1);
    wait_done();
    chk("a_error", {31'd0, error}, 32'd0);

    // Short line 3 (partial flush), long line 4.
    do_start();
    lens = '{16, 16, 16, 13, 18, 16};
    frame(6, -1, -1, 1'b1);
    wait_done();
    repeat (5) tick();
    chk("b_error_sticky", {31'd0, error}, 32'd1);

    // vsync arrives after 3 lines.
    do_start();
    lens = '{16, 16, 16, 16, 16, 16};
    frame(3, -1, -1, 1'b1);
    wait_done();
    chk("c_error", {31'd0, error}, 32'd1);

    // Reset on line 2, then an unarmed frame must write nothing.
    do_start();
    frame(6, -1, 2, 1'b1);
    frame(6, -1, -1, 1'b0);
    repeat (10) tick();
    chk("d_idle_busy", {31'd0, busy}, 32'd0);

    // Recovery frame after reset.
    do_start();
    frame(6, -1, -1, 1'b1);
    wait_done();
    chk("e_error", {31'd0, error}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
